cic_decimator: RTL and testbench

Parametrised N-stage cascaded integrator-comb (CIC) decimator; next generation of the single-configuration decimation filter. Accepts a signed sample stream with a valid strobe. Decimates by a runtime-selectable ratio up to `R_MAX` and emits one full-precision or truncated signed output per ratio period. Sits between the input-sample front end and the output/readout logic of the tile; adds runtime ratio, bypass mode and synchronous flush.

---
 rtl/cic_pkg.sv | 31 +++
 rtl/cic_decimator_comb.sv | 28 ++
 rtl/cic_decimator.sv | 118 +++++++++++
 tb/tb_cic_decimator.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/cic_pkg.sv
// Shared helpers and types for the CIC decimator.
// Width math and ratio clamping live here so top and bench agree.
package cic_pkg;

    function automatic int clog2i(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < v) r = i + 1;
        end
        return r;
    endfunction

    function automatic int acc_width(input int in_w, input int n, input int r_max);
        return in_w + n * clog2i(r_max);
    endfunction

    function automatic int clamp_ratio(input int r, input int r_max);
        if (r < 2) return 2;
        if (r > r_max) return r_max;
        return r;
    endfunction

    localparam int DEF_IN_W  = 8;
    localparam int DEF_N     = 3;
    localparam int DEF_R_MAX = 16;
    localparam int DEF_ACC_W = acc_width(DEF_IN_W, DEF_N, DEF_R_MAX);

    typedef logic signed [DEF_ACC_W-1:0] acc_t;

endpackage

// File: rtl/cic_decimator_comb.sv
// One registered CIC differentiator (M = 1).
// Advances only when enabled; flush zeroes both output and delay.
module cic_comb_stage #(
    parameter int W = 20
) (
    input  logic                clk,
    input  logic                flush_i,
    input  logic                en_i,
    input  logic signed [W-1:0] x_i,
    output logic signed [W-1:0] y_o
);

    logic signed [W-1:0] prev_q;
    logic signed [W-1:0] y_q;

    always_ff @(posedge clk) begin
        if (flush_i) begin
            prev_q <= '0;
            y_q    <= '0;
        end else if (en_i) begin
            y_q    <= x_i - prev_q;
            prev_q <= x_i;
        end
    end

    assign y_o = y_q;

endmodule

// File: rtl/cic_decimator.sv
// N-stage CIC decimator with runtime ratio, bypass and synchronous flush.
// Integrators are inline; combs are a generate chain of cic_comb_stage.
module cic_decimator
    import cic_pkg::*;
#(
    parameter int IN_W     = 8,
    parameter int N_STAGES = 3,
    parameter int R_MAX    = 16,
    parameter int OUT_W    = 20
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       clear,
    input  logic                       bypass,
    input  logic [clog2i(R_MAX):0]     dec_ratio,
    input  logic                       in_valid,
    input  logic signed [IN_W-1:0]     in_data,
    output logic                       out_valid,
    output logic signed [OUT_W-1:0]    out_data
);

    localparam int RW    = clog2i(R_MAX) + 1;
    localparam int ACC_W = acc_width(IN_W, N_STAGES, R_MAX);

    typedef logic signed [ACC_W-1:0] sacc_t;
    typedef logic signed [OUT_W-1:0] sout_t;

    sacc_t             integ_q [N_STAGES];
    sacc_t             integ_d [N_STAGES];
    sacc_t             comb_y  [N_STAGES];
    sacc_t             lat_q;
    logic [RW-1:0]     phase_q;
    logic [RW-1:0]     ratio_q;
    logic [RW-1:0]     ratio_clamped;
    logic [N_STAGES:0] sv_q;
    logic              wrap;
    logic              flush;
    logic              comb_flush;
    logic              byp_vld_q;
    logic              byp_mode_q;
    sout_t             byp_data_q;

    assign ratio_clamped = RW'(clamp_ratio(int'(dec_ratio), R_MAX));
    assign wrap          = in_valid && (phase_q == ratio_q - RW'(1));
    assign flush         = clear | bypass;
    assign comb_flush    = rst | flush;

    // Registered chain: each stage adds the previous stage's old value.
    always_comb begin
        for (int k = 0; k < N_STAGES; k++) integ_d[k] = integ_q[k];
        if (in_valid) begin
            integ_d[0] = integ_q[0] + sacc_t'(in_data);
            for (int k = 1; k < N_STAGES; k++) begin
                integ_d[k] = integ_q[k] + integ_q[k-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < N_STAGES; k++) integ_q[k] <= '0;
            phase_q <= '0;
            ratio_q <= ratio_clamped;
            lat_q   <= '0;
            sv_q    <= '0;
        end else if (flush) begin
            for (int k = 0; k < N_STAGES; k++) integ_q[k] <= '0;
            phase_q <= '0;
            lat_q   <= '0;
            sv_q    <= '0;
        end else begin
            if (in_valid) begin
                for (int k = 0; k < N_STAGES; k++) integ_q[k] <= integ_d[k];
                phase_q <= wrap ? '0 : phase_q + RW'(1);
            end
            if (wrap) begin
                lat_q   <= integ_d[N_STAGES-1];
                ratio_q <= ratio_clamped;
            end
            sv_q <= {sv_q[N_STAGES-1:0], wrap};
        end
    end

    for (genvar k = 0; k < N_STAGES; k++) begin : g_comb
        sacc_t stage_x;
        if (k == 0) begin : g_first
            assign stage_x = lat_q;
        end else begin : g_rest
            assign stage_x = comb_y[k-1];
        end
        cic_comb_stage #(.W(ACC_W)) u_stage (
            .clk     (clk),
            .flush_i (comb_flush),
            .en_i    (sv_q[k]),
            .x_i     (stage_x),
            .y_o     (comb_y[k])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            byp_vld_q  <= 1'b0;
            byp_mode_q <= 1'b0;
            byp_data_q <= '0;
        end else begin
            byp_mode_q <= bypass;
            byp_vld_q  <= bypass & in_valid;
            if (bypass && in_valid) begin
                byp_data_q <= sout_t'(in_data) <<< (OUT_W - IN_W);
            end
        end
    end

    assign out_valid = byp_vld_q | sv_q[N_STAGES];
    assign out_data  = (byp_vld_q | byp_mode_q) ? byp_data_q
                                                : comb_y[N_STAGES-1][ACC_W-1 -: OUT_W];

endmodule

// File: tb/tb_cic_decimator.sv
// Scoreboard bench for cic_decimator against a closed-form CIC model.
module tb_cic_decimator;

    localparam int IN_W  = 8;
    localparam int N     = 3;
    localparam int R_MAX = 16;
    localparam int OUT_W = 20;
    localparam int ACC_W = IN_W + N * 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                    rst = 1'b1;
    logic                    clear = 1'b0;
    logic                    bypass = 1'b0;
    logic                    in_valid = 1'b0;
    logic signed [IN_W-1:0]  in_data = '0;
    logic [4:0]              dec_ratio = 5'd4;
    logic                    out_valid;
    logic signed [OUT_W-1:0] out_data;

    cic_decimator #(
        .IN_W(IN_W), .N_STAGES(N), .R_MAX(R_MAX), .OUT_W(OUT_W)
    ) dut (
        .clk(clk), .rst(rst), .clear(clear), .bypass(bypass),
        .dec_ratio(dec_ratio), .in_valid(in_valid), .in_data(in_data),
        .out_valid(out_valid), .out_data(out_data)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int                      due;
        logic signed [OUT_W-1:0] data;
    } exp_t;

    exp_t   exp_q[$];
    int     checks = 0;
    int     errors = 0;
    longint xs[$];
    longint vh[$];
    int     m_phase = 0;
    int     m_ratio = 4;

    function automatic int clampr(input int r);
        if (r < 2) return 2;
        if (r > R_MAX) return R_MAX;
        return r;
    endfunction

    function automatic longint binom(input longint a, input int b);
        longint r;
        r = 1;
        if (a < 0 || a < b) return 0;
        for (int i = 0; i < b; i++) r = r * (a - i) / (i + 1);
        return r;
    endfunction

    function automatic logic signed [OUT_W-1:0] to_out(input longint v);
        logic [ACC_W-1:0] a;
        a = ACC_W'(v);
        return a[ACC_W-1 -: OUT_W];
    endfunction

    function automatic void purge(input int k);
        exp_t keep[$];
        foreach (exp_q[i]) if (exp_q[i].due <= k) keep.push_back(exp_q[i]);
        exp_q = keep;
    endfunction

    // Last integrator after sample n is sum x[j]*C(n-j, N-1); combs are an N-th difference.
    function automatic void accept(input longint x, input int k, input int ratio);
        longint il;
        longint y;
        int     n;
        int     idx;
        exp_t   e;
        xs.push_back(x);
        m_phase++;
        if (m_phase == m_ratio) begin
            m_phase = 0;
            n = xs.size() - 1;
            il = 0;
            for (int j = 0; j <= n; j++) il += xs[j] * binom(n - j, N - 1);
            il = il & ((longint'(1) << ACC_W) - 1);
            vh.push_back(il);
            y = 0;
            for (int kk = 0; kk <= N; kk++) begin
                idx = vh.size() - 1 - kk;
                if (idx >= 0) begin
                    if (kk % 2 == 0) y += binom(N, kk) * vh[idx];
                    else y -= binom(N, kk) * vh[idx];
                end
            end
            e.due = k + N + 1;
            e.data = to_out(y);
            exp_q.push_back(e);
            m_ratio = clampr(ratio);
        end
    endfunction

    task automatic drive(input bit r, input bit c, input bit b,
                         input bit v, input int d, input int ratio);
        int   k;
        exp_t e;
        @(negedge clk);
        #1;
        rst = r;
        clear = c;
        bypass = b;
        in_valid = v;
        in_data = IN_W'(d);
        dec_ratio = 5'(ratio);
        k = cyc;
        if (r || c || b) begin
            purge(k);
            xs.delete();
            vh.delete();
            m_phase = 0;
            if (r) m_ratio = clampr(ratio);
            if (b && v && !r) begin
                e.due = k + 1;
                e.data = OUT_W'(longint'(in_data) * 4096);
                exp_q.push_back(e);
            end
        end else if (v) begin
            accept(longint'(in_data), k, ratio);
        end
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        while (exp_q.size() > 0 && exp_q[0].due < cyc) begin
            e = exp_q.pop_front();
            checks++;
            errors++;
            $display("FAIL missing_out cyc=%0d got=none want=%0d@%0d", cyc, e.data, e.due);
        end
        if (out_valid === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_out cyc=%0d got=%0d want=none", cyc, out_data);
            end else begin
                e = exp_q.pop_front();
                if (e.due != cyc || out_data !== e.data) begin
                    errors++;
                    $display("FAIL out cyc=%0d got=%0d want=%0d@%0d",
                             cyc, out_data, e.data, e.due);
                end
            end
        end
    end

    initial begin
        int ratio;
        for (int i = 0; i < 3; i++) drive(1, 0, 0, 0, 0, 4);
        drive(0, 0, 0, 0, 0, 4);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_valid got=%b want=0", out_valid);
        end
        checks++;
        if (out_data !== '0) begin
            errors++;
            $display("FAIL reset_data got=%0d want=0", out_data);
        end

        for (int i = 0; i < 40; i++) drive(0, 0, 0, 1, 1, 4);

        drive(1, 0, 0, 0, 0, 16);
        for (int i = 0; i < 100; i++) drive(0, 0, 0, 1, -128, 16);
        drive(1, 0, 0, 0, 0, 16);
        for (int i = 0; i < 100; i++) drive(0, 0, 0, 1, 127, 16);

        drive(1, 0, 0, 0, 0, 4);
        for (int i = 0; i < 2; i++) drive(0, 0, 0, 1, 1, 4);
        for (int i = 0; i < 26; i++) drive(0, 0, 0, 1, 1, 8);
        for (int i = 0; i < 10; i++) drive(0, 0, 0, 1, 3, 0);
        for (int i = 0; i < 40; i++) drive(0, 0, 0, 1, -2, 31);

        drive(1, 0, 0, 0, 0, 4);
        for (int i = 0; i < 48; i++) drive(0, 0, 0, (i % 3) == 0, 1, 4);

        drive(0, 0, 1, 1, 5, 4);
        drive(0, 0, 1, 0, 0, 4);
        drive(0, 0, 1, 1, -3, 4);
        drive(0, 0, 1, 0, 0, 4);
        for (int i = 0; i < 12; i++) drive(0, 0, 0, 1, $urandom_range(0, 255), 4);

        drive(1, 0, 0, 0, 0, 4);
        for (int i = 0; i < 6; i++) drive(0, 0, 0, 1, $urandom_range(0, 255), 4);
        drive(0, 1, 0, 1, 9, 4);
        for (int i = 0; i < 12; i++) drive(0, 0, 0, 1, 2, 4);

        for (int i = 0; i < 7; i++) drive(0, 0, 0, 1, 1, 4);
        drive(1, 0, 0, 0, 0, 2);
        for (int i = 0; i < 20; i++) drive(0, 0, 0, 1, $urandom_range(0, 255), 2);

        ratio = 4;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 19) == 0) ratio = $urandom_range(0, 31);
            drive($urandom_range(0, 99) == 0, $urandom_range(0, 49) == 0,
                  $urandom_range(0, 39) == 0, $urandom_range(0, 9) < 7,
                  $urandom_range(0, 255), ratio);
        end

        for (int i = 0; i < 12; i++) drive(0, 0, 0, 0, 0, ratio);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain got=%0d want=0 pending", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
